// File: rtl/i2s_video_pkg.sv
// Shared types and pixel packing for the mono-8 I2S video link.
// Pixels are RGB888 in, 3-3-2 out, four per 32-bit word.
package i2s_video_pkg;

  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  function automatic logic [7:0] pack332(
    input logic [23:0] px
  );
    return {px[23:21], px[15:13], px[7:6]};
  endfunction

  // p0 lands in [7:0]
  function automatic logic [31:0] pack_word(
    input logic [95:0] w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < PIX_PER_WORD; i++)
      r[i*8 +: 8] = pack332(w[i*24 +: 24]);
    return r;
  endfunction

endpackage

// File: rtl/i2s_video_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Pointers carry an extra wrap bit; pop on empty is ignored.
module i2s_video_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge mclk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (do_push && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/i2s_video_frame_ctrl.sv
// Frame scheduler between the pixel pipeline and the I2S serializer.
// Frames are admitted at v_sync edges when the ESP signals cts.
module i2s_video_frame_ctrl
  import i2s_video_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int WORDS_PER_FRAME = 19200,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        v_sync,
  input  logic        cts,
  input  logic        in_valid,
  input  logic [95:0] in_data,
  output logic        in_ready,
  output logic [31:0] ser_word,
  output logic        ser_valid,
  input  logic        ser_take,
  output logic        send_frame,
  output logic [15:0] frame_count,
  output logic        underflow,
  output logic        short_frame
);

  localparam int CW = $clog2(WORDS_PER_FRAME) + 1;

  state_e                 state;
  logic [SYNC_STAGES-1:0] vs_sync;
  logic [SYNC_STAGES-1:0] cts_sync;
  logic                   vs_d;
  logic                   vs_rise;
  logic                   cts_s;
  logic [CW-1:0]          word_cnt;
  logic                   ready_en;
  logic                   last_take;
  logic                   streaming;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_flush;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [31:0]            fifo_dout;

  always_ff @(posedge mclk) begin
    if (reset) begin
      vs_sync  <= '0;
      cts_sync <= '0;
      vs_d     <= 1'b0;
    end else begin
      vs_sync  <= {vs_sync[SYNC_STAGES-2:0], v_sync};
      cts_sync <= {cts_sync[SYNC_STAGES-2:0], cts};
      vs_d     <= vs_sync[SYNC_STAGES-1];
    end
  end

  assign vs_rise = vs_sync[SYNC_STAGES-1] & ~vs_d;
  assign cts_s   = cts_sync[SYNC_STAGES-1];

  assign streaming = (state == STREAM);
  assign last_take = ser_take &&
                     (word_cnt == CW'(WORDS_PER_FRAME - 1));

  // Outside STREAM the input side drains freely into a held flush.
  assign in_ready   = ready_en & (~streaming | ~fifo_full);
  assign ser_valid  = streaming & ~fifo_empty;
  assign ser_word   = ser_valid ? fifo_dout : '0;
  assign fifo_flush = ~streaming | vs_rise;
  assign fifo_push  = streaming & ~vs_rise & in_valid & in_ready;
  assign fifo_pop   = streaming & ser_take;

  i2s_video_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .mclk  (mclk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (pack_word(in_data)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      state       <= IDLE;
      send_frame  <= 1'b0;
      word_cnt    <= '0;
      frame_count <= '0;
      underflow   <= 1'b0;
      short_frame <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (vs_rise) begin
            state      <= cts_s ? STREAM : IDLE;
            send_frame <= cts_s;
            word_cnt   <= '0;
          end
        end
        STREAM: begin
          if (ser_take) begin
            word_cnt <= word_cnt + 1'b1;
            if (fifo_empty)
              underflow <= 1'b1;
          end
          if (vs_rise) begin
            if (last_take)
              frame_count <= frame_count + 16'd1;
            else
              short_frame <= 1'b1;
            word_cnt   <= '0;
            state      <= cts_s ? STREAM : IDLE;
            send_frame <= cts_s;
          end else if (last_take) begin
            frame_count <= frame_count + 16'd1;
            word_cnt    <= '0;
            state       <= DONE;
            send_frame  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          send_frame <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_video_frame_ctrl.sv
// Directed bench for i2s_video_frame_ctrl with a 4-word frame.
// Expected values are hand-derived from the 3-3-2 packing rules.
module tb_i2s_video_frame_ctrl;
  import i2s_video_pkg::*;

  logic        mclk = 1'b0;
  logic        reset;
  logic        v_sync;
  logic        cts;
  logic        in_valid;
  logic [95:0] in_data;
  logic        in_ready;
  logic [31:0] ser_word;
  logic        ser_valid;
  logic        ser_take;
  logic        send_frame;
  logic [15:0] frame_count;
  logic        underflow;
  logic        short_frame;

  int n_chk  = 0;
  int n_fail = 0;

  i2s_video_frame_ctrl #(
    .FIFO_DEPTH      (8),
    .WORDS_PER_FRAME (4),
    .SYNC_STAGES     (2)
  ) dut (
    .mclk        (mclk),
    .reset       (reset),
    .v_sync      (v_sync),
    .cts         (cts),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ser_word    (ser_word),
    .ser_valid   (ser_valid),
    .ser_take    (ser_take),
    .send_frame  (send_frame),
    .frame_count (frame_count),
    .underflow   (underflow),
    .short_frame (short_frame)
  );

  always #5 mclk = ~mclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // word whose p0 packs to b, other pixels zero
  function automatic logic [95:0] mkword(input logic [7:0] b);
    return {72'h0, b[7:5], 5'b0, b[4:2], 5'b0, b[1:0], 6'b0};
  endfunction

  task automatic push(input logic [95:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic take();
    ser_take = 1'b1;
    tick(1);
    ser_take = 1'b0;
  endtask

  task automatic wait_send();
    for (int i = 0; i < 4 && send_frame !== 1'b1; i++)
      tick(1);
    chk("send_frame_up", 32'(send_frame), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    v_sync   = 1'b0;
    cts      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ser_take = 1'b0;
    tick(2);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_ser_word", ser_word, 32'd0);
    chk("rst_send", 32'(send_frame), 32'd0);
    chk("rst_fcount", 32'(frame_count), 32'd0);
    chk("rst_uflow", 32'(underflow), 32'd0);
    chk("rst_short", 32'(short_frame), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("idle_ready", 32'(in_ready), 32'd1);

    cts    = 1'b1;
    v_sync = 1'b1;
    wait_send();

    push({4{24'hFF00FF}});
    chk("w0_valid", 32'(ser_valid), 32'd1);
    chk("w0_word", ser_word, 32'hE3E3E3E3);
    take();
    chk("w0_popped", 32'(ser_valid), 32'd0);
    chk("w0_cnt", 32'(dut.word_cnt), 32'd1);

    push({72'h0, 24'h00E0C0});
    chk("p0_lsb", ser_word, 32'h0000001F);
    take();
    chk("w1_cnt", 32'(dut.word_cnt), 32'd2);

    chk("empty_word", ser_word, 32'd0);
    take();
    chk("uflow_set", 32'(underflow), 32'd1);
    chk("uflow_cnt", 32'(dut.word_cnt), 32'd3);
    push(mkword(8'h55));
    chk("w3_word", ser_word, 32'h00000055);
    take();
    chk("done_fcount", 32'(frame_count), 32'd1);
    chk("done_state", 32'(dut.state), 32'(DONE));
    chk("done_send", 32'(send_frame), 32'd0);
    chk("done_short", 32'(short_frame), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd1);

    v_sync = 1'b0;
    cts    = 1'b0;
    tick(3);
    v_sync = 1'b1;
    tick(4);
    chk("nocts_state", 32'(dut.state), 32'(IDLE));
    in_data  = mkword(8'hAA);
    in_valid = 1'b1;
    tick(2);
    in_valid = 1'b0;
    chk("nocts_fifo", 32'(dut.fifo_empty), 32'd1);
    chk("nocts_valid", 32'(ser_valid), 32'd0);
    chk("nocts_ready", 32'(in_ready), 32'd1);
    chk("nocts_send", 32'(send_frame), 32'd0);

    v_sync = 1'b0;
    cts    = 1'b1;
    tick(3);
    v_sync = 1'b1;
    wait_send();
    for (int k = 1; k <= 8; k++) begin
      in_data  = mkword(8'(k));
      in_valid = 1'b1;
      tick(1);
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_head", ser_word, 32'd1);
    in_data = mkword(8'd9);
    tick(1);
    chk("full_hold", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    take();
    chk("full_freed", 32'(in_ready), 32'd1);
    chk("full_next", ser_word, 32'd2);
    chk("full_cnt", 32'(dut.word_cnt), 32'd1);
    take();
    chk("short_pre", ser_word, 32'd3);

    v_sync = 1'b0;
    tick(3);
    v_sync = 1'b1;
    for (int i = 0; i < 4 && short_frame !== 1'b1; i++)
      tick(1);
    chk("short_set", 32'(short_frame), 32'd1);
    chk("short_fifo", 32'(dut.fifo_empty), 32'd1);
    chk("short_fcount", 32'(frame_count), 32'd1);
    chk("short_state", 32'(dut.state), 32'(STREAM));
    chk("short_cnt", 32'(dut.word_cnt), 32'd0);
    chk("short_send", 32'(send_frame), 32'd1);

    push(mkword(8'h07));
    chk("mid_valid", 32'(ser_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("mrst_ready", 32'(in_ready), 32'd0);
    chk("mrst_valid", 32'(ser_valid), 32'd0);
    chk("mrst_word", ser_word, 32'd0);
    chk("mrst_send", 32'(send_frame), 32'd0);
    chk("mrst_fcount", 32'(frame_count), 32'd0);
    chk("mrst_uflow", 32'(underflow), 32'd0);
    chk("mrst_short", 32'(short_frame), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("post_ready", 32'(in_ready), 32'd1);
    chk("post_state", 32'(dut.state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
